// File: rtl/pulse_train_generator.sv
// Pulse train generator: on a trigger edge emits delay, then N high/low pulses (or runs until aborted).
// Ports: clk_i/rst_ni, trig_i/abort_i/retrig_i/continuous_i control, delay_i/high_i/low_i/n_pulses_i config,
//        wave_o/busy_o/done_o/pulse_count_o registered status outputs.
module pulse_train_generator #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned N_WIDTH = 16,
   parameter bit          INVERT  = 1'b0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               trig_i,
   input  logic               abort_i,
   input  logic               retrig_i,
   input  logic               continuous_i,
   input  logic [WIDTH-1:0]   delay_i,
   input  logic [WIDTH-1:0]   high_i,
   input  logic [WIDTH-1:0]   low_i,
   input  logic [N_WIDTH-1:0] n_pulses_i,
   output logic               wave_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [N_WIDTH-1:0] pulse_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   high_q, high_d;
   logic [WIDTH-1:0]   low_q, low_d;
   logic [N_WIDTH-1:0] n_q, n_d;
   logic               cont_q, cont_d;
   logic [N_WIDTH-1:0] pcount_q, pcount_d;
   logic               trig_q, trig_d;
   logic               wave_q, wave_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               trig_edge;
   logic               accept;

   // The phase counter holds "cycles remaining minus one", so a phase of
   // length max(v,1) expires when the counter reads zero.
   function automatic logic [WIDTH-1:0] phase_len(input logic [WIDTH-1:0] v);
      phase_len = (v == '0) ? '0 : v - WIDTH'(1);
   endfunction

   assign trig_edge = trig_i & ~trig_q;
   // Busy is judged from the current state, so a trigger on the completing
   // edge with retrig_i=0 is ignored.
   assign accept    = trig_edge & ((state_q == ST_IDLE) | retrig_i);
   assign trig_d    = trig_i;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         high_q   <= '0;
         low_q    <= '0;
         n_q      <= '0;
         cont_q   <= 1'b0;
         pcount_q <= '0;
         trig_q   <= 1'b1;
         wave_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         high_q   <= high_d;
         low_q    <= low_d;
         n_q      <= n_d;
         cont_q   <= cont_d;
         pcount_q <= pcount_d;
         trig_q   <= trig_d;
         wave_q   <= wave_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state and phase datapath
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      high_d   = high_q;
      low_d    = low_q;
      n_d      = n_q;
      cont_d   = cont_q;
      pcount_d = pcount_q;
      if (abort_i) begin
         state_d = ST_IDLE;
      end else if (accept) begin
         high_d   = high_i;
         low_d    = low_i;
         n_d      = (n_pulses_i == '0) ? N_WIDTH'(1) : n_pulses_i;
         cont_d   = continuous_i;
         pcount_d = '0;
         if (delay_i == '0) begin
            state_d = ST_HIGH;
            cnt_d   = phase_len(high_i);
         end else begin
            state_d = ST_DELAY;
            cnt_d   = phase_len(delay_i);
         end
      end else begin
         case (state_q)
            ST_DELAY: begin
               if (cnt_q == '0) begin
                  state_d = ST_HIGH;
                  cnt_d   = phase_len(high_q);
               end else begin
                  cnt_d = cnt_q - WIDTH'(1);
               end
            end
            ST_HIGH: begin
               if (cnt_q == '0) begin
                  pcount_d = pcount_q + N_WIDTH'(1);
                  if (!cont_q && (pcount_d == n_q)) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_LOW;
                     cnt_d   = phase_len(low_q);
                  end
               end else begin
                  cnt_d = cnt_q - WIDTH'(1);
               end
            end
            ST_LOW: begin
               if (cnt_q == '0) begin
                  state_d = ST_HIGH;
                  cnt_d   = phase_len(high_q);
               end else begin
                  cnt_d = cnt_q - WIDTH'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      wave_d = (state_d == ST_HIGH);
      busy_d = (state_d != ST_IDLE);
      // Only a HIGH phase running out reaches IDLE without abort.
      done_d = (state_q == ST_HIGH) && (state_d == ST_IDLE) && !abort_i;
   end

   assign wave_o        = INVERT ? ~wave_q : wave_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign pulse_count_o = pcount_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
module tb_pulse_train_generator;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        trig_i, abort_i, retrig_i, continuous_i;
   logic [31:0] delay_i, high_i, low_i;
   logic [15:0] n_pulses_i;
   logic        wave_o, busy_o, done_o;
   logic [15:0] pulse_count_o;
   logic        wave2, busy2, done2;
   logic [3:0]  cnt2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pulse_train_generator #(.WIDTH(32), .N_WIDTH(16), .INVERT(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .trig_i(trig_i), .abort_i(abort_i),
      .retrig_i(retrig_i), .continuous_i(continuous_i), .delay_i(delay_i),
      .high_i(high_i), .low_i(low_i), .n_pulses_i(n_pulses_i),
      .wave_o(wave_o), .busy_o(busy_o), .done_o(done_o),
      .pulse_count_o(pulse_count_o)
   );

   // Narrow-counter, inverted-output instance sharing the same stimulus.
   pulse_train_generator #(.WIDTH(32), .N_WIDTH(4), .INVERT(1'b1)) dut2 (
      .clk_i(clk), .rst_ni(rst_ni), .trig_i(trig_i), .abort_i(abort_i),
      .retrig_i(retrig_i), .continuous_i(continuous_i), .delay_i(delay_i),
      .high_i(high_i), .low_i(low_i), .n_pulses_i(n_pulses_i[3:0]),
      .wave_o(wave2), .busy_o(busy2), .done_o(done2),
      .pulse_count_o(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Outputs are sampled on the falling edge, i.e. "after edge e".
   initial begin
      rst_ni = 1'b0; trig_i = 1'b1; abort_i = 1'b0; retrig_i = 1'b0;
      continuous_i = 1'b0; delay_i = 0; high_i = 0; low_i = 0; n_pulses_i = 0;
      repeat (3) @(negedge clk);
      check("rst_wave", wave_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_count", pulse_count_o, 0);
      check("rst_wave_inv", wave2, 1);

      // trig_i held high through reset release must not start a train
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("trig_held_busy", busy_o, 0);
         check("trig_held_wave_inv", wave2, 1);
      end
      trig_i = 1'b0;
      @(negedge clk);

      // Finite train D=2 H=3 L=2 N=3; config changed after trigger must be ignored
      delay_i = 2; high_i = 3; low_i = 2; n_pulses_i = 3;
      trig_i = 1'b1;
      @(negedge clk);
      trig_i = 1'b0; delay_i = 9; high_i = 9; low_i = 9; n_pulses_i = 9;
      for (int e = 0; e <= 17; e++) begin
         check("fin_wave", wave_o, ((e >= 2 && e < 5) || (e >= 7 && e < 10) || (e >= 12 && e < 15)) ? 1 : 0);
         check("fin_count", pulse_count_o, (e < 5) ? 0 : (e < 10) ? 1 : (e < 15) ? 2 : 3);
         check("fin_done", done_o, (e == 15) ? 1 : 0);
         check("fin_busy", busy_o, (e < 15) ? 1 : 0);
         @(negedge clk);
      end

      // All-zero configuration
      delay_i = 0; high_i = 0; low_i = 0; n_pulses_i = 0;
      trig_i = 1'b1;
      @(negedge clk);
      trig_i = 1'b0;
      check("zero_wave_e0", wave_o, 1);
      check("zero_busy_e0", busy_o, 1);
      check("zero_done_e0", done_o, 0);
      @(negedge clk);
      check("zero_wave_e1", wave_o, 0);
      check("zero_busy_e1", busy_o, 0);
      check("zero_done_e1", done_o, 1);
      check("zero_count_e1", pulse_count_o, 1);
      @(negedge clk);
      check("zero_done_e2", done_o, 0);
      check("zero_count_e2", pulse_count_o, 1);

      // Retrigger enabled: second edge at 5 restarts the train
      delay_i = 0; high_i = 4; low_i = 4; n_pulses_i = 2; retrig_i = 1'b1;
      trig_i = 1'b1;
      @(negedge clk);
      for (int e = 0; e <= 19; e++) begin
         trig_i = (e == 4);
         check("rt1_wave", wave_o, ((e < 4) || (e >= 5 && e < 9) || (e >= 13 && e < 17)) ? 1 : 0);
         check("rt1_count", pulse_count_o, (e < 4) ? 0 : (e == 4) ? 1 : (e < 9) ? 0 : (e < 17) ? 1 : 2);
         check("rt1_done", done_o, (e == 17) ? 1 : 0);
         check("rt1_busy", busy_o, (e < 17) ? 1 : 0);
         @(negedge clk);
      end

      // Retrigger disabled: second edge ignored
      retrig_i = 1'b0;
      trig_i = 1'b1;
      @(negedge clk);
      for (int e = 0; e <= 15; e++) begin
         trig_i = (e == 4);
         check("rt0_wave", wave_o, ((e < 4) || (e >= 8 && e < 12)) ? 1 : 0);
         check("rt0_count", pulse_count_o, (e < 4) ? 0 : (e < 12) ? 1 : 2);
         check("rt0_done", done_o, (e == 12) ? 1 : 0);
         check("rt0_busy", busy_o, (e < 12) ? 1 : 0);
         @(negedge clk);
      end

      // Abort together with a trigger edge at 7, continuous H=L=2
      delay_i = 0; high_i = 2; low_i = 2; n_pulses_i = 1; continuous_i = 1'b1;
      trig_i = 1'b1;
      @(negedge clk);
      trig_i = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         check("ab_wave_pre", wave_o, ((e % 4) < 2) ? 1 : 0);
         check("ab_busy_pre", busy_o, 1);
         if (e == 6) begin
            abort_i = 1'b1; trig_i = 1'b1;
         end
         @(negedge clk);
      end
      for (int e = 7; e <= 10; e++) begin
         if (e == 8) abort_i = 1'b0;
         if (e == 9) trig_i = 1'b0;
         check("ab_wave", wave_o, 0);
         check("ab_busy", busy_o, 0);
         check("ab_done", done_o, 0);
         check("ab_count", pulse_count_o, 2);
         @(negedge clk);
      end

      // Continuous H=L=1: narrow counter wraps 15 -> 0 on the 16th pulse
      delay_i = 0; high_i = 1; low_i = 1; continuous_i = 1'b1;
      trig_i = 1'b1;
      @(negedge clk);
      trig_i = 1'b0;
      for (int e = 0; e <= 34; e++) begin
         check("wrap_wave_inv", wave2, (e % 2 == 0) ? 0 : 1);
         check("wrap_count4", cnt2, ((e + 1) / 2) % 16);
         check("wrap_done", done2, 0);
         check("wrap_count16", pulse_count_o, (e + 1) / 2);
         if (e == 34) rst_ni = 1'b0;   // mid-HIGH reset
         @(negedge clk);
      end
      check("midrst_wave", wave_o, 0);
      check("midrst_wave_inv", wave2, 1);
      check("midrst_busy", busy_o, 0);
      check("midrst_done", done_o, 0);
      check("midrst_count", pulse_count_o, 0);
      check("midrst_count4", cnt2, 0);
      rst_ni = 1'b1; continuous_i = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_busy", busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pulse_train_generator.md
# pulse_train_generator

Parametrised successor to the single-shot square-wave block: on a trigger it emits a train of pulses with programmable start delay, high time, low time and pulse count, or runs continuously until aborted. Adds retrigger, abort, completion strobe and pulse counting. Sits between the trigger/edge-source logic and the DAC/digital-output mux, one instance per output line.

## Interface
- `WIDTH`, 32: width of the delay, high and low cycle counts.
- `N_WIDTH`, 16: width of the pulse count and the pulse counter.
- `INVERT`, 0: if 1, `wave_o` is the logical inverse of the internal wave, including during reset.
- `clk_i` in 1: system clock; all logic on its rising edge.
- `rst_ni` in 1: reset, synchronous and active-low.
- `trig_i` in 1: trigger level; the rising edge starts a train.
- `abort_i` in 1: synchronous stop, level-sensitive.
- `retrig_i` in 1: 1 = a trigger edge while busy restarts the train; 0 = it is ignored.
- `continuous_i` in 1: 1 = repeat pulses until aborted; `n_pulses_i` ignored.
- `delay_i` in WIDTH: cycles from trigger to the first high.
- `high_i` in WIDTH: high-phase length in cycles.
- `low_i` in WIDTH: low-phase length in cycles.
- `n_pulses_i` in N_WIDTH: pulses per train.
- `wave_o` out 1: registered pulse output.
- `busy_o` out 1: high while a train is active.
- `done_o` out 1: one-cycle strobe when a finite train completes.
- `pulse_count_o` out N_WIDTH: completed pulses in the current or last train.

## Operation
- Edge detect: `trig_q` register holds the previous `trig_i`. The trigger is `trig_i & ~trig_q`, combinational. `trig_q` resets to 1, so `trig_i` held high through reset release does not trigger.
- FSM states: IDLE, DELAY, HIGH, LOW. A single WIDTH-bit phase counter is loaded on phase entry.
- Phase length rule: each phase lasts exactly max(value,1) cycles. Zero is treated as 1.
- Config latch: `delay_i`, `high_i`, `low_i`, `n_pulses_i` and `continuous_i` are latched at the accepted trigger. Later input changes have no effect on the running train.
- `n_pulses_i`=0 is treated as 1.
- Accepted trigger, from IDLE (or from any state when `retrig_i`=1):
  - latch config;
  - clear `pulse_count_o`;
  - enter DELAY, or HIGH directly if the latched delay is 0.
- DELAY → HIGH when the phase count expires.
- At the end of a HIGH phase, `pulse_count_o` increments (wraps modulo 2^N_WIDTH). Then:
  - continuous: → LOW;
  - count reached the latched N: → IDLE, with `done_o`=1 for one cycle;
  - otherwise: → LOW.
- No trailing LOW after the last pulse.
- LOW → HIGH when the phase count expires.
- `abort_i`=1: → IDLE next edge; wave low; `busy_o` low; `done_o` not asserted; `pulse_count_o` holds its value.
- Priority: reset > abort > trigger > phase progression.
  - Abort and trigger in the same cycle: abort wins; the trigger is discarded.
  - Trigger with `retrig_i`=0 on the same edge the train completes: ignored, because busy is still set.
- `pulse_count_o` holds after completion until the next accepted trigger.

## Timing
- All outputs are registered.
- Reset values: `wave_o`=INVERT, `busy_o`=0, `done_o`=0, `pulse_count_o`=0, state IDLE, `trig_q`=1.
- Reset mid-train returns everything to the reset values on the next edge; the train is not resumed.
- Trigger accepted at edge T0:
  - `busy_o`=1 after T0;
  - `wave_o` rises after T0+D' (D'=latched delay; D'=0 rises after T0);
  - high for H' cycles, low for L' cycles, so the period is H'+L'.
- Completion:
  - at the edge ending the last HIGH, `wave_o` falls, `busy_o` falls, `done_o`=1 and `pulse_count_o`=N' together;
  - `done_o` clears on the next edge.
- Retrigger at edge Tr: the new train timing is measured from Tr exactly as from T0. A HIGH in progress is cut off at Tr unless the new D'=0.

## Test plan
- **Finite train:** D=2, H=3, L=2, N=3, trigger at edge 0.
  - Wave high after edges 2, 7, 12; low after 5, 10, 15.
  - `pulse_count_o` steps 1, 2, 3 at edges 5, 10, 15.
  - `done_o` one cycle after edge 15; `busy_o` high over edges 0–15.
- **All zero:** D=H=L=N=0, trigger at edge 0.
  - Wave high for exactly one cycle (after edge 0, low after edge 1).
  - `done_o` after edge 1; `pulse_count_o`=1.
- **Retrigger:** D=0, H=4, L=4, N=2, trigger at 0, second edge at 5.
  - `retrig_i`=1: count cleared at 5; pulses after 5 and 13; done after 17.
  - `retrig_i`=0: second edge ignored; done after 12.
- **Abort:** continuous, H=L=2. Assert abort and a trigger edge together at edge 7.
  - Wave low, busy low after 7; no `done_o`; `pulse_count_o` holds 2; trigger dropped.
- **Continuous wrap:** N_WIDTH=4, H=L=1, continuous.
  - `pulse_count_o` goes 15 → 0 on the 16th pulse.
  - Wave keeps toggling every cycle; `done_o` never asserts.
- **Reset:**
  - Reset mid-HIGH: all outputs reach reset values at the next edge.
  - With `trig_i` held high through reset release: no train starts until `trig_i` goes low then high.
  - With INVERT=1: `wave_o`=1 while idle.
